// File: rtl/pipeline_flow_ctrl_if.sv
// Hazard/event inputs and stall/flush/redirect outputs of the pipeline flow controller.
// Optional FC_PERF_CNT_EN adds the stall and redirect performance counters.
interface pipeline_flow_ctrl_if #(
   parameter int unsigned PC_W = 32
);
   logic            id_load_use_i;
   logic            ex_jump_i;
   logic [PC_W-1:0] ex_jump_pc_i;
   logic            ex_div_start_i;
   logic            div_done_i;
   logic            mem_req_i;
   logic            mem_ack_i;
   logic            if_busy_i;
   logic            trap_i;
   logic [PC_W-1:0] trap_pc_i;

   logic            fc_stall_pc_o;
   logic            fc_stall_ifid_o;
   logic            fc_stall_idex_o;
   logic            fc_stall_exmem_o;
   logic            fc_flush_ifid_o;
   logic            fc_flush_idex_o;
   logic            fc_flush_exmem_o;
   logic            fc_redirect_o;
   logic [PC_W-1:0] fc_redirect_pc_o;
   logic [1:0]      fc_state_o;
`ifdef FC_PERF_CNT_EN
   logic [31:0]     fc_stall_cnt_o;
   logic [31:0]     fc_redir_cnt_o;
`endif

   // Controller side.
   modport master (
      input  id_load_use_i, ex_jump_i, ex_jump_pc_i, ex_div_start_i, div_done_i,
      input  mem_req_i, mem_ack_i, if_busy_i, trap_i, trap_pc_i,
      output fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o,
      output fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o,
      output fc_redirect_o, fc_redirect_pc_o, fc_state_o
`ifdef FC_PERF_CNT_EN
      , output fc_stall_cnt_o, fc_redir_cnt_o
`endif
   );

   // Pipeline side.
   modport slave (
      output id_load_use_i, ex_jump_i, ex_jump_pc_i, ex_div_start_i, div_done_i,
      output mem_req_i, mem_ack_i, if_busy_i, trap_i, trap_pc_i,
      input  fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o,
      input  fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o,
      input  fc_redirect_o, fc_redirect_pc_o, fc_state_o
`ifdef FC_PERF_CNT_EN
      , input fc_stall_cnt_o, fc_redir_cnt_o
`endif
   );
endinterface

// File: rtl/pipeline_flow_ctrl.sv
// Central stall/flush/redirect controller for the five-stage core with a 4-state event FSM.
// Optional FC_PERF_CNT_EN adds free-running stall and accepted-redirect counters.
module pipeline_flow_ctrl #(
   parameter int unsigned PC_W = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   pipeline_flow_ctrl_if.master fc
);

   typedef enum logic [1:0] {
      StRun       = 2'd0,
      StMemWait   = 2'd1,
      StDivWait   = 2'd2,
      StRedirHold = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] held_pc_q, held_pc_d;

   logic            stall_pc, stall_ifid, stall_idex, stall_exmem;
   logic            flush_ifid, flush_idex, flush_exmem;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic            do_trap, do_tail, do_low;

   always_comb begin
      state_d     = state_q;
      held_pc_d   = held_pc_q;
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      stall_exmem = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      do_trap     = 1'b0;
      do_tail     = 1'b0;
      do_low      = 1'b0;

      unique case (state_q)
         StRun: begin
            if (fc.trap_i) begin
               do_trap = 1'b1;
            end else if (fc.mem_req_i && !fc.mem_ack_i) begin
               {stall_pc, stall_ifid, stall_idex, stall_exmem} = 4'b1111;
               state_d = StMemWait;
            end else begin
               do_tail = 1'b1;
            end
         end
         StMemWait: begin
            if (fc.trap_i) begin
               do_trap = 1'b1;
            end else if (!fc.mem_ack_i) begin
               {stall_pc, stall_ifid, stall_idex, stall_exmem} = 4'b1111;
            end else begin
               do_tail = 1'b1;
               state_d = StRun;
            end
         end
         StDivWait: begin
            if (fc.trap_i) begin
               do_trap = 1'b1;
            end else if (!fc.div_done_i) begin
               {stall_pc, stall_ifid, stall_idex} = 3'b111;
               flush_exmem = 1'b1;
            end else begin
               do_low  = 1'b1;
               state_d = StRun;
            end
         end
         StRedirHold: begin
            redirect    = 1'b1;
            flush_ifid  = 1'b1;
            redirect_pc = held_pc_q;
            // A trap while holding replaces the pending target.
            if (fc.trap_i) begin
               redirect_pc = fc.trap_pc_i;
               held_pc_d   = fc.trap_pc_i;
            end
            if (!fc.if_busy_i) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase

      if (do_trap) begin
         {flush_ifid, flush_idex, flush_exmem} = 3'b111;
         redirect    = 1'b1;
         redirect_pc = fc.trap_pc_i;
         if (fc.if_busy_i) begin
            held_pc_d = fc.trap_pc_i;
            state_d   = StRedirHold;
         end else begin
            state_d = StRun;
         end
      end

      // Rules below the memory-wait check, shared by RUN and the MEM_WAIT ack cycle.
      if (do_tail) begin
         if (fc.ex_div_start_i) begin
            {stall_pc, stall_ifid, stall_idex} = 3'b111;
            flush_exmem = 1'b1;
            state_d     = StDivWait;
         end else if (fc.ex_jump_i) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            redirect    = 1'b1;
            redirect_pc = fc.ex_jump_pc_i;
            if (fc.if_busy_i) begin
               held_pc_d = fc.ex_jump_pc_i;
               state_d   = StRedirHold;
            end
         end else begin
            do_low = 1'b1;
         end
      end

      if (do_low) begin
         if (fc.id_load_use_i) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
         end else if (fc.if_busy_i) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StRun;
         held_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         held_pc_q <= held_pc_d;
      end
   end

   always_comb begin
      fc.fc_stall_pc_o    = stall_pc;
      fc.fc_stall_ifid_o  = stall_ifid;
      fc.fc_stall_idex_o  = stall_idex;
      fc.fc_stall_exmem_o = stall_exmem;
      fc.fc_flush_ifid_o  = flush_ifid;
      fc.fc_flush_idex_o  = flush_idex;
      fc.fc_flush_exmem_o = flush_exmem;
      fc.fc_redirect_o    = redirect;
      fc.fc_redirect_pc_o = redirect_pc;
      fc.fc_state_o       = state_q;
   end

`ifdef FC_PERF_CNT_EN
   logic [31:0] stall_cnt_q, redir_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         if (stall_pc) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         // Count only redirects fetch actually accepts.
         if (redirect && !fc.if_busy_i) begin
            redir_cnt_q <= redir_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      fc.fc_stall_cnt_o = stall_cnt_q;
      fc.fc_redir_cnt_o = redir_cnt_q;
   end
`endif

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Scoreboard bench for pipeline_flow_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_pipeline_flow_ctrl;

   logic clk;
   logic rst_n;

   pipeline_flow_ctrl_if #(.PC_W(32)) fc_if ();

   pipeline_flow_ctrl #(.PC_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fc    (fc_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  st;
      logic [7:0]  ctl;  // stall pc,ifid,idex,exmem, flush ifid,idex,exmem, redirect
      logic [31:0] pc;
      bit          cnt_zero;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic clear_in();
      fc_if.id_load_use_i  = 1'b0;
      fc_if.ex_jump_i      = 1'b0;
      fc_if.ex_jump_pc_i   = '0;
      fc_if.ex_div_start_i = 1'b0;
      fc_if.div_done_i     = 1'b0;
      fc_if.mem_req_i      = 1'b0;
      fc_if.mem_ack_i      = 1'b0;
      fc_if.if_busy_i      = 1'b0;
      fc_if.trap_i         = 1'b0;
      fc_if.trap_pc_i      = '0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic expect_out(input string name, input logic [1:0] st, input logic [7:0] ctl,
                             input logic [31:0] pc, input bit cnt_zero = 1'b0);
      exp_t e;
      e.name     = name;
      e.st       = st;
      e.ctl      = ctl;
      e.pc       = pc;
      e.cnt_zero = cnt_zero;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [7:0] act;
         e   = exp_q.pop_front();
         act = {fc_if.fc_stall_pc_o, fc_if.fc_stall_ifid_o, fc_if.fc_stall_idex_o,
                fc_if.fc_stall_exmem_o, fc_if.fc_flush_ifid_o, fc_if.fc_flush_idex_o,
                fc_if.fc_flush_exmem_o, fc_if.fc_redirect_o};
         checks++;
         if (act !== e.ctl || fc_if.fc_state_o !== e.st || fc_if.fc_redirect_pc_o !== e.pc) begin
            failures++;
            $display("FAIL %s: got state=%0d ctl=%b pc=%h, want state=%0d ctl=%b pc=%h",
                     e.name, fc_if.fc_state_o, act, fc_if.fc_redirect_pc_o, e.st, e.ctl, e.pc);
         end
`ifdef FC_PERF_CNT_EN
         if (e.cnt_zero) begin
            checks++;
            if (fc_if.fc_stall_cnt_o !== 32'd0 || fc_if.fc_redir_cnt_o !== 32'd0) begin
               failures++;
               $display("FAIL %s_cnt: got stall=%0d redir=%0d, want 0/0", e.name,
                        fc_if.fc_stall_cnt_o, fc_if.fc_redir_cnt_o);
            end
         end
`endif
      end
   end

   // ctl bit patterns
   localparam logic [7:0] Idle   = 8'b0000_0000;
   localparam logic [7:0] StAll  = 8'b1111_0000;
   localparam logic [7:0] LdUse  = 8'b1100_0100;
   localparam logic [7:0] Busy   = 8'b1000_1000;
   localparam logic [7:0] DivSt  = 8'b1110_0010;
   localparam logic [7:0] JmpRd  = 8'b0000_1101;
   localparam logic [7:0] HoldRd = 8'b0000_1001;
   localparam logic [7:0] TrapRd = 8'b0000_1111;

   initial begin
      rst_n = 1'b0;
      clear_in();
      #1;
      expect_out("reset", 2'd0, Idle, 32'h0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      next_cyc(); expect_out("idle", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.id_load_use_i = 1'b1; expect_out("load_use", 2'd0, LdUse, 32'h0);
      next_cyc(); expect_out("load_use_after", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.if_busy_i = 1'b1; expect_out("if_busy", 2'd0, Busy, 32'h0);

      next_cyc(); fc_if.mem_req_i = 1'b1; expect_out("mem_c0", 2'd0, StAll, 32'h0);
      for (int i = 1; i <= 3; i++) begin
         next_cyc(); fc_if.mem_req_i = 1'b1; expect_out("mem_wait", 2'd1, StAll, 32'h0);
      end
      next_cyc(); fc_if.mem_req_i = 1'b1; fc_if.mem_ack_i = 1'b1;
      expect_out("mem_ack", 2'd1, Idle, 32'h0);
      next_cyc(); expect_out("mem_done", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.mem_req_i = 1'b1; fc_if.mem_ack_i = 1'b1;
      expect_out("mem_zero_wait", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.ex_div_start_i = 1'b1; expect_out("div_t0", 2'd0, DivSt, 32'h0);
      for (int i = 1; i <= 7; i++) begin
         next_cyc(); expect_out("div_wait", 2'd2, DivSt, 32'h0);
      end
      next_cyc(); fc_if.div_done_i = 1'b1; expect_out("div_done", 2'd2, Idle, 32'h0);
      next_cyc(); expect_out("div_after", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.ex_jump_i = 1'b1; fc_if.ex_jump_pc_i = 32'h100; fc_if.if_busy_i = 1'b1;
      expect_out("jump_busy_c0", 2'd0, JmpRd, 32'h100);
      for (int i = 1; i <= 2; i++) begin
         next_cyc(); fc_if.if_busy_i = 1'b1; expect_out("jump_hold", 2'd3, HoldRd, 32'h100);
      end
      next_cyc(); expect_out("jump_accept", 2'd3, HoldRd, 32'h100);
      next_cyc(); expect_out("jump_after", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.ex_jump_i = 1'b1; fc_if.ex_jump_pc_i = 32'h200;
      expect_out("jump_free", 2'd0, JmpRd, 32'h200);
      next_cyc(); expect_out("jump_free_after", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.mem_req_i = 1'b1; expect_out("tm_c0", 2'd0, StAll, 32'h0);
      next_cyc(); fc_if.mem_req_i = 1'b1; expect_out("tm_c1", 2'd1, StAll, 32'h0);
      next_cyc(); fc_if.mem_req_i = 1'b1; fc_if.trap_i = 1'b1; fc_if.trap_pc_i = 32'h80;
      expect_out("trap_in_memwait", 2'd1, TrapRd, 32'h80);
      next_cyc(); expect_out("trap_after", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.trap_i = 1'b1; fc_if.trap_pc_i = 32'h40; fc_if.if_busy_i = 1'b1;
      fc_if.mem_req_i = 1'b1; fc_if.ex_jump_i = 1'b1; fc_if.ex_jump_pc_i = 32'h300;
      expect_out("trap_prio_busy", 2'd0, TrapRd, 32'h40);
      next_cyc(); fc_if.if_busy_i = 1'b1; expect_out("trap_hold", 2'd3, HoldRd, 32'h40);
      next_cyc(); fc_if.if_busy_i = 1'b1; fc_if.trap_i = 1'b1; fc_if.trap_pc_i = 32'hC0;
      expect_out("trap_relatch", 2'd3, HoldRd, 32'hC0);
      next_cyc(); expect_out("trap_relatch_acc", 2'd3, HoldRd, 32'hC0);
      next_cyc(); expect_out("trap_hold_after", 2'd0, Idle, 32'h0);

      next_cyc(); fc_if.mem_req_i = 1'b1; fc_if.ex_div_start_i = 1'b1;
      expect_out("mem_over_div", 2'd0, StAll, 32'h0);
      next_cyc(); fc_if.mem_ack_i = 1'b1; fc_if.ex_div_start_i = 1'b1;
      expect_out("ack_then_div", 2'd1, DivSt, 32'h0);
      next_cyc(); fc_if.div_done_i = 1'b1; fc_if.id_load_use_i = 1'b1;
      expect_out("done_load_use", 2'd2, LdUse, 32'h0);

      next_cyc(); fc_if.id_load_use_i = 1'b1; fc_if.if_busy_i = 1'b1;
      expect_out("lu_over_busy", 2'd0, LdUse, 32'h0);

      next_cyc(); fc_if.ex_div_start_i = 1'b1; expect_out("rdiv_t0", 2'd0, DivSt, 32'h0);
      next_cyc(); expect_out("rdiv_wait", 2'd2, DivSt, 32'h0);
      next_cyc(); rst_n = 1'b0; expect_out("reset_mid_div", 2'd0, Idle, 32'h0, 1'b1);
      next_cyc(); rst_n = 1'b1; expect_out("post_reset", 2'd0, Idle, 32'h0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
